// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache fill responder and the cache fill FSMs.
package cache_mem_pkg;

  localparam int unsigned WORD_W         = 16;
  localparam int unsigned BLOCK_OFFSET_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst
  } fill_state_e;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: one synchronous write port, one combinational read port, no reset.
module mem_word_array #(
  parameter int unsigned AddrW = 15,
  parameter int unsigned DataW = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem [1 << AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/cache_fill_responder.sv
// Memory-side responder: single-word write-through stores and fixed-latency block-read bursts.
module cache_fill_responder
  import cache_mem_pkg::*;
#(
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned BURST_WORDS    = 8,
  parameter int unsigned MEM_WORDS_LOG2 = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic [WORD_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              busy
);

  localparam int unsigned LatW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CntW = $clog2(BURST_WORDS + 1);
  localparam logic [CntW-1:0] LastWord = CntW'(BURST_WORDS - 1);
  localparam logic [CntW-1:0] BurstEnd = CntW'(BURST_WORDS);

  fill_state_e state_q, state_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [CntW-1:0]   w_q, w_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
  logic [WORD_W-1:0] rsp_addr_q, rsp_addr_d;

  logic                      mem_we;
  logic [MEM_WORDS_LOG2-1:0] rd_idx;
  logic [WORD_W-1:0]         rd_data;
  logic                      unused_addr_bit;

  assign unused_addr_bit = req_addr[0];
  assign rd_idx = base_q[MEM_WORDS_LOG2:1] + MEM_WORDS_LOG2'(w_q);

  mem_word_array #(
    .AddrW (MEM_WORDS_LOG2),
    .DataW (WORD_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (req_addr[MEM_WORDS_LOG2:1]),
    .wdata_i (req_wdata),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    w_d         = w_q;
    base_d      = base_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = '0;
    rsp_addr_d  = '0;
    mem_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_wr) begin
            mem_we = 1'b1;
          end else begin
            base_d = {req_addr[WORD_W-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
            w_d    = '0;
            if (LATENCY > 1) begin
              state_d   = StWait;
              lat_cnt_d = LatW'(LATENCY - 1);
            end else begin
              state_d = StBurst;
            end
          end
        end
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - LatW'(1);
        if (lat_cnt_q == LatW'(1)) begin
          state_d = StBurst;
        end
      end
      StBurst: begin
        // One extra BURST cycle shows the last word, keeping req_ready low until after rsp_last.
        if (w_q == BurstEnd) begin
          state_d = StIdle;
          w_d     = '0;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = (w_q == LastWord);
          rsp_data_d  = rd_data;
          rsp_addr_d  = base_q + (WORD_W'(w_q) << 1);
          w_d         = w_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      lat_cnt_q   <= '0;
      w_q         <= '0;
      base_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      w_q         <= w_d;
      base_q      <= base_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_cache_fill_responder.sv
// Bench for cache_fill_responder: a LATENCY=4 and a LATENCY=1 instance against a word-array model.
module tb_cache_fill_responder;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wr    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data  [2];
  logic [15:0] rsp_addr  [2];
  logic        rsp_last  [2];
  logic        busy      [2];

  int n_checks = 0;
  int n_fail   = 0;

  bit [15:0]   mm     [2][32768];
  bit          mm_ok  [2][32768];
  logic [15:0] last_burst [2][8];
  logic [15:0] first_addr [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cache_fill_responder #(
      .LATENCY        (g == 0 ? 4 : 1),
      .BURST_WORDS    (8),
      .MEM_WORDS_LOG2 (15)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wr    (req_wr[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_addr  (rsp_addr[g]),
      .rsp_last  (rsp_last[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input int d, input string name);
    chk(name, {rsp_valid[d], rsp_last[d], busy[d], req_ready[d], rsp_data[d], rsp_addr[d]},
        {4'b0001, 32'h0});
  endtask

  // Called at a negedge; the write is taken on the following posedge.
  task automatic do_write(input int d, input logic [15:0] a, input logic [15:0] v);
    req_valid[d] = 1'b1;
    req_wr[d]    = 1'b1;
    req_addr[d]  = a;
    req_wdata[d] = v;
    chk("wr_ready", {63'b0, req_ready[d]}, 64'd1);
    @(posedge clk);
    mm[d][a[15:1]]    = v;
    mm_ok[d][a[15:1]] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_wr[d]    = 1'b0;
    chk("wr_no_rsp", {62'b0, rsp_valid[d], req_ready[d]}, 64'd1);
  endtask

  // Called at a negedge. abort_c >= 0 pulls rst low right after sampling cycle abort_c.
  task automatic do_read(input int d, input logic [15:0] a, input bit hold,
                         input logic [15:0] hold_a, input int abort_c);
    int          lat;
    int          n;
    int          w;
    bit          exp_v;
    logic [15:0] base;
    logic [15:0] ea;
    lat  = (d == 0) ? 4 : 1;
    base = a & 16'hFFF0;
    req_valid[d] = 1'b1;
    req_wr[d]    = 1'b0;
    req_addr[d]  = a;
    req_wdata[d] = 16'($urandom);
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      chk("rd_accept_timeout", {63'b0, req_ready[d]}, 64'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold) req_addr[d] = hold_a;
    else req_valid[d] = 1'b0;
    for (int c = 0; c <= lat + 8; c++) begin
      @(negedge clk);
      exp_v = (c >= lat) && (c < lat + 8);
      w     = c - lat;
      ea    = exp_v ? base + 16'(2 * w) : 16'h0;
      chk("rsp_ctrl", {60'b0, rsp_valid[d], rsp_last[d], busy[d], req_ready[d]},
          {60'b0, exp_v, exp_v && (w == 7), c < lat + 8, c >= lat + 8});
      chk("rsp_addr", {48'b0, rsp_addr[d]}, {48'b0, ea});
      if (!exp_v) begin
        chk("rsp_data_idle", {48'b0, rsp_data[d]}, 64'd0);
      end else begin
        last_burst[d][w] = rsp_data[d];
        if (w == 0) first_addr[d] = rsp_addr[d];
        if (mm_ok[d][ea[15:1]]) chk("rsp_data", {48'b0, rsp_data[d]}, {48'b0, mm[d][ea[15:1]]});
      end
      if (c == abort_c) begin
        #2 rst = 1'b0;
        #1 check_idle(d, "abort_async");
        repeat (2) begin
          @(negedge clk);
          check_idle(d, "abort_hold");
        end
        rst = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_base;
    int          chk_off;
    logic [15:0] chk_word;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{0, 1'b1, 16'h0042, 16'h1234, 16'h0000, 0, 16'h0000};
    tbl[1] = '{0, 1'b0, 16'h004C, 16'h0000, 16'h0040, 1, 16'h1234};
    tbl[2] = '{0, 1'b0, 16'h004F, 16'h0000, 16'h0040, 1, 16'h1234};
    tbl[3] = '{0, 1'b0, 16'hFFF8, 16'h0000, 16'hFFF0, 7, 16'hA007};
    tbl[4] = '{0, 1'b1, 16'h0042, 16'h5678, 16'h0000, 0, 16'h0000};
    tbl[5] = '{0, 1'b0, 16'h0040, 16'h0000, 16'h0040, 1, 16'h5678};
    tbl[6] = '{1, 1'b1, 16'h0000, 16'hBEEF, 16'h0000, 0, 16'h0000};
    tbl[7] = '{1, 1'b0, 16'h0008, 16'h0000, 16'h0000, 0, 16'hBEEF};

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_wr[i]    = 1'b0;
      req_addr[i]  = 16'h0;
      req_wdata[i] = 16'h0;
    end
    repeat (2) @(negedge clk);
    check_idle(0, "reset_d0");
    check_idle(1, "reset_d1");
    rst = 1'b1;
    @(negedge clk);
    check_idle(0, "post_reset_d0");

    for (int i = 0; i < 8; i++) do_write(0, 16'hFFF0 + 16'(2 * i), 16'hA000 + 16'(i));

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].d, tbl[i].addr, tbl[i].wdata);
      end else begin
        do_read(tbl[i].d, tbl[i].addr, 1'b0, 16'h0, -1);
        chk("tbl_base", {48'b0, first_addr[tbl[i].d]}, {48'b0, tbl[i].exp_base});
        chk("tbl_word", {48'b0, last_burst[tbl[i].d][tbl[i].chk_off]}, {48'b0, tbl[i].chk_word});
      end
    end

    // Second read held valid through the first burst.
    do_write(0, 16'h0104, 16'h0C0C);
    do_read(0, 16'h0100, 1'b1, 16'h0200, -1);
    chk("busy_first_base", {48'b0, first_addr[0]}, 64'h0100);
    chk("busy_first_word", {48'b0, last_burst[0][2]}, 64'h0C0C);
    do_read(0, 16'h0200, 1'b0, 16'h0, -1);
    chk("busy_second_base", {48'b0, first_addr[0]}, 64'h0200);

    // Reset during WAIT, then during the third burst word, then recovery.
    do_read(0, 16'h0300, 1'b0, 16'h0, 2);
    do_write(0, 16'h0014, 16'h7777);
    do_read(0, 16'h0050, 1'b0, 16'h0, 4 + 2);
    do_read(0, 16'h0010, 1'b0, 16'h0, -1);
    chk("abort_recover_word", {48'b0, last_burst[0][2]}, 64'h7777);
    do_read(1, 16'h0020, 1'b0, 16'h0, 1 + 2);
    do_read(1, 16'h0008, 1'b0, 16'h0, -1);
    chk("abort_recover_d1", {48'b0, last_burst[1][0]}, 64'hBEEF);

    for (int t = 0; t < 24; t++) begin
      int          d;
      logic [15:0] blk;
      d   = int'($urandom_range(0, 1));
      blk = 16'($urandom) & 16'hFFF0;
      for (int i = 0; i < 8; i++)
        do_write(d, blk + 16'(2 * i) + 16'($urandom_range(0, 1)), 16'($urandom));
      if ($urandom_range(0, 1) == 1)
        do_write(d, blk + 16'(2 * $urandom_range(0, 7)), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_read(d, blk | 16'($urandom_range(0, 15)), 1'b0, 16'h0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
